// File: rtl/ara_perf_pkg.sv
// Shared types and encodings for the Ara vector-runtime performance monitor.
package ara_perf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } perf_state_e;

  // Status word layout: snapshot count in the low bits, overflow flags above it
  // (runtime overflow first, then one flag per event channel).
  localparam int unsigned StatusSnapLsb = 0;

  function automatic int unsigned status_ovf_lsb(input int unsigned snap_w);
    return snap_w;
  endfunction

  // Read-select encoding: runtime buffer, event buffers, then the status word.
  function automatic int unsigned sel_runtime();
    return 0;
  endfunction

  function automatic int unsigned sel_event(input int unsigned k);
    return k + 1;
  endfunction

  function automatic int unsigned sel_status(input int unsigned nr_events);
    return nr_events + 1;
  endfunction

endpackage

// File: rtl/ara_perf_counter.sv
// Single performance counter with optional saturation and a sticky overflow flag.
module ara_perf_counter #(
  parameter int unsigned CntWidth = 64,
  parameter logic        Saturate = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                en_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                ovf_o
);

  logic [CntWidth-1:0] cnt_q;
  logic                ovf_q;

  // Count enabled cycles; at all-ones either hold or wrap, and latch the overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (en_i) begin
      if (&cnt_q) begin
        ovf_q <= 1'b1;
        if (!Saturate) cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/ara_vruntime_monitor.sv
// Vector-runtime and event monitor: counts cycles and events between the first
// dispatched vector instruction and Ara going idle, snapshots the counters at
// every idle point and exposes the snapshots through a registered read port.
module ara_vruntime_monitor
  import ara_perf_pkg::*;
#(
  parameter int unsigned NrEvents     = 3,
  parameter int unsigned CntWidth     = 64,
  parameter logic        Saturate     = 1'b0,
  parameter int unsigned SnapCntWidth = 16,
  localparam int unsigned NrCnt       = NrEvents + 1,
  localparam int unsigned SelWidth    = $clog2(NrEvents + 2)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sw_en_i,
  input  logic                vinsn_valid_i,
  input  logic                ara_idle_i,
  input  logic [NrEvents-1:0] event_i,
  input  logic                clear_i,
  input  logic                rd_req_i,
  input  logic [SelWidth-1:0] rd_sel_i,
  output logic                rd_valid_o,
  output logic [CntWidth-1:0] rd_data_o,
  output logic                counting_o,
  output logic                snapshot_o
);

  localparam int unsigned StatusW = SnapCntWidth + NrCnt;
  localparam int unsigned OvfLsb  = status_ovf_lsb(SnapCntWidth);

  perf_state_e                    state_q, state_d;
  logic                           counting_q;
  logic [NrCnt-1:0][CntWidth-1:0] cnt, buf_q;
  logic [NrCnt-1:0]               cnt_en, ovf;
  logic                           pending_q, snap_cond, do_snap, snapshot_q;
  logic [SnapCntWidth-1:0]        snap_cnt_q;
  logic [StatusW-1:0]             status;
  logic [CntWidth-1:0]            status_word;
  logic [NrCnt:0][CntWidth-1:0]   rd_chain;
  logic                           rd_valid_q;
  logic [CntWidth-1:0]            rd_data_q;

  // A clear in the same cycle as an idle point wins and drops the snapshot.
  assign snap_cond = pending_q & ara_idle_i & ~vinsn_valid_i;
  assign do_snap   = snap_cond & ~clear_i;

  // Window state register and registered counting flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      counting_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      counting_q <= (state_d != IDLE);
    end
  end

  // Window transitions: open on an enabled dispatch, drain until Ara is idle.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (vinsn_valid_i && sw_en_i) state_d = RUN;
        RUN:     if (!sw_en_i) state_d = ara_idle_i ? IDLE : DRAIN;
        DRAIN: begin
          if (sw_en_i)         state_d = RUN;
          else if (ara_idle_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter 0 is the runtime counter, counter k+1 tracks event channel k.
  assign cnt_en[0] = counting_q;
  for (genvar g = 0; g < NrEvents; g++) begin : g_ev_en
    assign cnt_en[g+1] = counting_q & event_i[g];
  end

  for (genvar g = 0; g < NrCnt; g++) begin : g_cnt
    ara_perf_counter #(
      .CntWidth(CntWidth),
      .Saturate(Saturate)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clear_i(clear_i),
      .en_i   (cnt_en[g]),
      .cnt_o  (cnt[g]),
      .ovf_o  (ovf[g])
    );

    if (g == 0) begin : g_rt_sel
      assign rd_chain[g+1] = rd_chain[g] |
          ((rd_sel_i == SelWidth'(sel_runtime())) ? buf_q[g] : '0);
    end else begin : g_ev_sel
      assign rd_chain[g+1] = rd_chain[g] |
          ((rd_sel_i == SelWidth'(sel_event(g - 1))) ? buf_q[g] : '0);
    end
  end

  // Pending dispatch tracking, snapshot buffers and snapshot count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q  <= 1'b0;
      snapshot_q <= 1'b0;
      snap_cnt_q <= '0;
      buf_q      <= '0;
    end else if (clear_i) begin
      pending_q  <= 1'b0;
      snapshot_q <= 1'b0;
      snap_cnt_q <= '0;
      buf_q      <= '0;
    end else begin
      snapshot_q <= do_snap;
      if (vinsn_valid_i)  pending_q <= 1'b1;
      else if (snap_cond) pending_q <= 1'b0;
      if (do_snap) begin
        buf_q <= cnt;
        if (!(&snap_cnt_q)) snap_cnt_q <= snap_cnt_q + SnapCntWidth'(1);
      end
    end
  end

  assign status[StatusSnapLsb +: SnapCntWidth] = snap_cnt_q;
  assign status[OvfLsb +: NrCnt]               = ovf;

  if (StatusW >= CntWidth) begin : g_status_trunc
    assign status_word = status[CntWidth-1:0];
  end else begin : g_status_pad
    assign status_word = {{(CntWidth - StatusW){1'b0}}, status};
  end

  // Unmatched selects fall through the OR chain as zero.
  assign rd_chain[0] = (rd_sel_i == SelWidth'(sel_status(NrEvents))) ? status_word : '0;

  // Registered read port; data holds between reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_req_i;
      if (rd_req_i) rd_data_q <= rd_chain[NrCnt];
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign counting_o = counting_q;
  assign snapshot_o = snapshot_q;

endmodule

// File: tb/tb_ara_vruntime_monitor.sv
// Scoreboard bench for ara_vruntime_monitor: one 64-bit wrapping instance and
// two 8-bit instances (saturating and wrapping) share the same stimulus.
module tb_ara_vruntime_monitor;

  localparam int NREV = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_en, vinsn, idle, clr, rd_req;
  logic [2:0] ev;
  logic [2:0] rd_sel;

  logic        v0, v1, v2, cn0, cn1, cn2, sp0, sp1, sp2;
  logic [63:0] d0;
  logic [7:0]  d1, d2;

  int errors = 0;
  int checks = 0;

  // Reference model: true (unbounded) increment counts per counter.
  int                m_state;
  bit                m_pend, m_snap;
  longint unsigned   m_snaps;
  longint unsigned   n_live[NREV+1];
  longint unsigned   n_buf[NREV+1];
  longint unsigned   exp_q[3][$];
  longint unsigned   hold_exp[3];
  int unsigned       cfg_w[3]   = '{64, 8, 8};
  bit                cfg_sat[3] = '{1'b0, 1'b1, 1'b0};
  int unsigned       cfg_sw[3]  = '{16, 4, 4};

  always #5 clk = ~clk;

  ara_vruntime_monitor #(.NrEvents(3), .CntWidth(64), .Saturate(1'b0), .SnapCntWidth(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .sw_en_i(sw_en), .vinsn_valid_i(vinsn), .ara_idle_i(idle),
    .event_i(ev), .clear_i(clr), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
    .rd_valid_o(v0), .rd_data_o(d0), .counting_o(cn0), .snapshot_o(sp0));

  ara_vruntime_monitor #(.NrEvents(3), .CntWidth(8), .Saturate(1'b1), .SnapCntWidth(4)) u_sat (
    .clk_i(clk), .rst_i(rst), .sw_en_i(sw_en), .vinsn_valid_i(vinsn), .ara_idle_i(idle),
    .event_i(ev), .clear_i(clr), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
    .rd_valid_o(v1), .rd_data_o(d1), .counting_o(cn1), .snapshot_o(sp1));

  ara_vruntime_monitor #(.NrEvents(3), .CntWidth(8), .Saturate(1'b0), .SnapCntWidth(4)) u_wrap (
    .clk_i(clk), .rst_i(rst), .sw_en_i(sw_en), .vinsn_valid_i(vinsn), .ara_idle_i(idle),
    .event_i(ev), .clear_i(clr), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
    .rd_valid_o(v2), .rd_data_o(d2), .counting_o(cn2), .snapshot_o(sp2));

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint unsigned mask(input int unsigned w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic longint unsigned exp_cnt(input longint unsigned n, input int unsigned w, input bit sat);
    if (n <= mask(w)) return n;
    return sat ? mask(w) : (n & mask(w));
  endfunction

  function automatic bit ovf_of(input longint unsigned n, input int unsigned w);
    return (w < 64) && (n > mask(w));
  endfunction

  function automatic longint unsigned exp_read(input int d, input int unsigned sel);
    logic [127:0]    s;
    longint unsigned smax;
    if (sel <= NREV) return exp_cnt(n_buf[sel], cfg_w[d], cfg_sat[d]);
    if (sel == NREV + 1) begin
      smax     = mask(cfg_sw[d]);
      s        = '0;
      s[63:0]  = (m_snaps > smax) ? smax : m_snaps;
      for (int i = 0; i <= NREV; i++) s[cfg_sw[d] + i] = ovf_of(n_live[i], cfg_w[d]);
      return s[63:0] & mask(cfg_w[d]);
    end
    return 64'd0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pend = 0; m_snap = 0; m_snaps = 0;
    for (int i = 0; i <= NREV; i++) begin n_live[i] = 0; n_buf[i] = 0; end
    for (int d = 0; d < 3; d++) begin exp_q[d].delete(); hold_exp[d] = 0; end
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    bit cond;
    cond = m_pend && idle && !vinsn;
    if (rd_req) for (int d = 0; d < 3; d++) exp_q[d].push_back(exp_read(d, rd_sel));
    if (clr) begin
      m_state = 0; m_pend = 0; m_snap = 0; m_snaps = 0;
      for (int i = 0; i <= NREV; i++) begin n_live[i] = 0; n_buf[i] = 0; end
    end else begin
      m_snap = cond;
      if (cond) begin
        n_buf = n_live;
        m_snaps++;
      end
      if (m_state != 0) begin
        n_live[0]++;
        for (int k = 0; k < NREV; k++) if (ev[k]) n_live[k+1]++;
      end
      if (vinsn) m_pend = 1;
      else if (cond) m_pend = 0;
      case (m_state)
        0: if (vinsn && sw_en) m_state = 1;
        1: if (!sw_en) m_state = idle ? 0 : 2;
        default: if (sw_en) m_state = 1; else if (idle) m_state = 0;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    @(negedge clk);
  endtask

  task automatic chk_port(input int d, input logic v, input longint unsigned data);
    longint unsigned e;
    if (v) begin
      if (exp_q[d].size() == 0) begin
        chk($sformatf("rd_unexpected_valid%0d", d), v, 0);
      end else begin
        e = exp_q[d].pop_front();
        hold_exp[d] = e;
        chk($sformatf("rd_data%0d", d), data, e);
      end
    end else begin
      if (exp_q[d].size() != 0) begin
        chk($sformatf("rd_valid_missing%0d", d), v, 1);
        void'(exp_q[d].pop_front());
      end
      chk($sformatf("rd_hold%0d", d), data, hold_exp[d]);
    end
  endtask

  // Monitor: pops expected reads whenever a DUT presents rd_valid_o.
  always @(negedge clk) begin
    if (!rst) begin
      chk_port(0, v0, d0);
      chk_port(1, v1, 64'(d1));
      chk_port(2, v2, 64'(d2));
      chk("counting0", cn0, (m_state != 0));
      chk("counting1", cn1, (m_state != 0));
      chk("counting2", cn2, (m_state != 0));
      chk("snapshot0", sp0, m_snap);
      chk("snapshot1", sp1, m_snap);
      chk("snapshot2", sp2, m_snap);
    end
  end

  task automatic rd_direct(input string nm, input int unsigned sel,
                           input longint unsigned e0, input longint unsigned e1,
                           input longint unsigned e2);
    rd_req = 1'b1;
    rd_sel = 3'(sel);
    tick();
    rd_req = 1'b0;
    chk({nm, "_valid"}, v0, 1);
    chk(nm, d0, e0);
    chk({nm, "_sat8"}, 64'(d1), e1);
    chk({nm, "_wrap8"}, 64'(d2), e2);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic trigger();
    vinsn = 1'b1;
    idle  = 1'b0;
    tick();
    vinsn = 1'b0;
  endtask

  initial begin
    sw_en = 0; vinsn = 0; idle = 1; ev = '0; clr = 0; rd_req = 0; rd_sel = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rd_valid", v0, 0);
    chk("rst_rd_data", d0, 0);
    chk("rst_counting", cn0, 0);
    chk("rst_snapshot", sp0, 0);
    rst = 1'b0;

    // Window count: 20 counted cycles before Ara returns idle.
    sw_en = 1; idle = 1;
    repeat (2) tick();
    trigger();
    repeat (20) tick();
    idle = 1;
    tick();
    chk("win_snap_pulse", sp0, 1);
    tick();
    chk("win_snap_single", sp0, 0);
    rd_direct("win_rt", 0, 20, 20, 20);
    rd_direct("win_status", 4, 1, 1, 1);

    // Drain after disable: 5 RUN cycles + 7 DRAIN cycles.
    do_clear();
    trigger();
    repeat (5) tick();
    sw_en = 0;
    repeat (7) tick();
    chk("drain_counting", cn0, 1);
    idle = 1;
    tick();
    tick();
    chk("drain_idle", cn0, 0);
    rd_direct("drain_rt", 0, 12, 12, 12);

    // Events: IDLE-time strobes are ignored.
    sw_en = 1; idle = 1;
    do_clear();
    ev = 3'b111;
    repeat (3) tick();
    trigger();
    ev = 3'b101;
    repeat (5) tick();
    ev = 3'b010;
    repeat (4) tick();
    ev = 3'b000; idle = 1;
    tick();
    rd_direct("ev_rt", 0, 9, 9, 9);
    rd_direct("ev0", 1, 5, 5, 5);
    rd_direct("ev1", 2, 4, 4, 4);
    rd_direct("ev2", 3, 5, 5, 5);

    // Overflow: 300 counted cycles into 8-bit counters.
    do_clear();
    trigger();
    repeat (300) tick();
    idle = 1;
    tick();
    rd_direct("ovf_rt", 0, 300, 255, 44);
    rd_direct("ovf_status", 4, 1, 17, 17);

    // Clear coinciding with a snapshot condition.
    do_clear();
    trigger();
    repeat (6) tick();
    idle = 1; clr = 1;
    tick();
    clr = 0;
    chk("clr_no_snap", sp0, 0);
    tick();
    chk("clr_no_snap_late", sp0, 0);
    chk("clr_idle", cn0, 0);
    rd_direct("clr_rt", 0, 0, 0, 0);
    rd_direct("clr_ev0", 1, 0, 0, 0);
    rd_direct("clr_status", 4, 0, 0, 0);
    trigger();
    repeat (3) tick();
    idle = 1;
    tick();
    rd_direct("restart_rt", 0, 3, 3, 3);

    // Back-to-back reads: runtime, event0, out-of-range.
    rd_req = 1; rd_sel = 3'd0;
    tick();
    chk("bb_v0", v0, 1); chk("bb_rt", d0, 3);
    rd_sel = 3'd1;
    tick();
    chk("bb_v1", v0, 1); chk("bb_ev0", d0, 0);
    rd_sel = 3'd7;
    tick();
    chk("bb_v2", v0, 1); chk("bb_oob", d0, 0);
    rd_req = 0;
    tick();
    chk("bb_done", v0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      sw_en  = ($urandom_range(0, 9) != 0);
      vinsn  = ($urandom_range(0, 9) == 0);
      idle   = ($urandom_range(0, 9) < 6);
      ev     = 3'($urandom);
      clr    = ($urandom_range(0, 49) == 0);
      rd_req = $urandom_range(0, 1);
      rd_sel = 3'($urandom_range(0, 7));
      tick();
    end
    vinsn = 0; ev = '0; clr = 0; rd_req = 0; sw_en = 1; idle = 1;
    tick();

    // Asynchronous reset in the middle of a counting window.
    do_clear();
    trigger();
    repeat (4) tick();
    idle = 1;
    tick();
    rd_direct("pre_rst_rt", 0, 4, 4, 4);
    chk("pre_rst_counting", cn0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rd_valid", v0, 0);
    chk("arst_rd_data", d0, 0);
    chk("arst_counting", cn0, 0);
    chk("arst_snapshot", sp0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    rd_direct("post_rst_rt", 0, 0, 0, 0);
    rd_direct("post_rst_status", 4, 0, 0, 0);

    repeat (3) tick();
    for (int d = 0; d < 3; d++) chk($sformatf("queue_drained%0d", d), exp_q[d].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ara_vruntime_monitor.md
Name: ara_vruntime_monitor

Overview:
Parametrised vector-runtime and event performance monitor for the Ara SoC testbench/SoC top.
- Measures cycles from the first vector instruction dispatched to Ara until Ara returns idle, gated by a software enable.
- Accumulates NrEvents generic event counters (e.g. I$/D$ miss, scoreboard full) over the same window.
- On each idle point, snapshots all counters into buffers that are read through a registered read port.

Parameters:
NrEvents, 3, number of event counter channels (1..16)
CntWidth, 64, width of runtime and event counters (8..64)
Saturate, 1'b0, 1 = counters saturate at all-ones; 0 = counters wrap
SnapCntWidth, 16, width of the saturating snapshot counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
sw_en_i  in  1  software counter enable (hw_cnt_en)
vinsn_valid_i  in  1  vector instruction request valid towards Ara
ara_idle_i  in  1  Ara idle
event_i  in  NrEvents  per-channel event strobes, counted once per cycle when high
clear_i  in  1  synchronous clear of all counters, buffers and flags
rd_req_i  in  1  read request
rd_sel_i  in  $clog2(NrEvents+2)  read select
rd_valid_o  out  1  read data valid
rd_data_o  out  CntWidth  read data
counting_o  out  1  counting window active
snapshot_o  out  1  one-cycle pulse when buffers are updated

Behaviour:
- Reset: state IDLE; all live counters, buffers, overflow flags, snapshot count and pending flag = 0; rd_valid_o = 0; rd_data_o = 0; counting_o = 0; snapshot_o = 0.
- FSM states (all transitions registered):
  - IDLE -> RUN when vinsn_valid_i & sw_en_i.
  - RUN -> DRAIN when !sw_en_i & !ara_idle_i.
  - RUN -> IDLE when !sw_en_i & ara_idle_i.
  - DRAIN -> IDLE when sw_en_i is low and ara_idle_i is high.
  - DRAIN -> RUN when sw_en_i is high.
  - counting_o = (state != IDLE), registered.
- Counting:
  - Runtime counter increments every cycle counting_o = 1.
  - Event counter k increments when counting_o & event_i[k].
  - The first counted cycle is the cycle after the IDLE -> RUN trigger.
- Overflow:
  - Saturate = 1: a counter at all-ones holds its value.
  - Saturate = 0: it wraps to 0.
  - In both modes a per-counter sticky overflow bit is set on the increment attempted at all-ones.
- Pending flag:
  - Set on vinsn_valid_i, independent of sw_en_i.
  - Snapshot condition: pending & ara_idle_i & !vinsn_valid_i.
- Snapshot:
  - Copies live counter values (pre-increment, i.e. the _q values) into the buffers.
  - Clears pending; pulses snapshot_o for 1 cycle (registered, the cycle after the condition).
  - Increments snapshot count, saturating at all-ones.
  - Live counters are not cleared; repeated snapshots within one enable window give monotonically increasing values.
- Simultaneous events:
  - Snapshot condition and vinsn_valid_i can never coincide by definition.
  - Snapshot concurrent with RUN -> IDLE is allowed; buffers take the _q value.
- clear_i:
  - Highest priority; in the same edge zeroes counters, buffers, overflow, snapshot count and pending, and forces IDLE.
  - A clear concurrent with a snapshot condition suppresses the snapshot (no pulse).
- Read port:
  - rd_req_i sampled at the edge; rd_valid_o = 1 and rd_data_o valid exactly 1 cycle later; reads accepted every cycle (back-to-back).
  - rd_sel_i = 0: runtime buffer.
  - rd_sel_i = 1..NrEvents: event buffer rd_sel_i-1.
  - rd_sel_i = NrEvents+1: status word = {zero-pad, overflow bits [NrEvents:0] with runtime overflow at bit 0, snapshot count}, packed LSB-first; snapshot count occupies bits [SnapCntWidth-1:0] and overflow bits sit above it.
  - Any other select returns 0 with rd_valid_o = 1.
  - rd_data_o holds its last value when rd_valid_o = 0.
- Reset asserted mid-window returns all state to reset values immediately (asynchronous); no snapshot is produced.

Decomposition:
- Shared package ara_perf_pkg:
  - FSM state enum (IDLE, RUN, DRAIN).
  - Status-word field offsets.
  - Select-encoding function sel_runtime/sel_event(k)/sel_status.
- Sub-module ara_perf_counter: one CntWidth counter with en, clear, Saturate parameter and sticky overflow output.
  - Instantiated NrEvents+1 times (runtime + events).
- Top module holds the FSM, pending/snapshot logic, buffers and read mux.

Test Plan:
- Window count: sw_en_i = 1; vinsn_valid_i pulse at cycle 10; ara_idle_i low for cycles 10..29 then high; no further valid -> snapshot_o pulses once; sel 0 reads 20; sel NrEvents+1 reads snapshot count 1.
- Drain after disable: enter RUN; drop sw_en_i while ara_idle_i = 0 for 7 more cycles -> state DRAIN; counting continues 7 cycles then IDLE; runtime buffer includes the drain cycles.
- Events: event_i = 3'b101 for 5 counted cycles and 3'b010 for 4 cycles, plus event pulses while IDLE -> buffers read 5, 4, 5; IDLE-time events are ignored.
- Overflow: CntWidth = 8; 300 counted cycles, run once with Saturate = 1 and once with Saturate = 0 -> Saturate = 1 reads 255; Saturate = 0 reads 44; overflow bit 0 = 1 in the status word in both runs.
- Clear priority: clear_i asserted in the same cycle as a snapshot condition -> no snapshot_o; all reads return 0; state IDLE; the next vinsn_valid_i restarts counting from 0.
- Read timing and reset: back-to-back rd_req_i with sel 0, 1, 7 (out of range) -> rd_valid_o on 3 consecutive cycles with data runtime, event0, 0; rst_i asserted mid-RUN -> all outputs 0 within the same cycle.
